// File: rtl/bag_random_generator.sv
// Piece randomiser: a Galois LFSR drives either 7-bag permutations or uniform
// rejection-sampled draws, delivered one item at a time over valid/ready.
module bag_random_generator #(
    parameter int                 width_p     = 16,
    parameter logic [width_p-1:0] taps_p      = 16'hB400,
    parameter logic [width_p-1:0] seed_p      = 16'hACE1,
    parameter int                 num_items_p = 7,
    parameter int                 max_tries_p = 16,
    localparam int                idx_w       = $clog2(num_items_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               mode_i,
    input  logic               seed_v_i,
    input  logic [width_p-1:0] seed_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [idx_w-1:0]   item_o,
    output logic [idx_w:0]     remaining_o
);

    localparam int tries_w = (max_tries_p > 1) ? $clog2(max_tries_p) : 1;
    localparam logic [tries_w-1:0] last_try = tries_w'(max_tries_p - 1);
    localparam logic [tries_w-1:0] one_try  = tries_w'(1);
    localparam logic [idx_w:0]     n_c      = (idx_w + 1)'(num_items_p);
    localparam logic [idx_w:0]     one_rem  = (idx_w + 1)'(1);
    localparam logic [idx_w-1:0]   n_low    = n_c[idx_w-1:0];

    typedef enum logic [1:0] {FILL, DRAW, OUT} state_t;
    typedef logic [num_items_p-1:0] bag_t;

    state_t               state, state_n;
    logic [width_p-1:0]   lfsr, lfsr_n;
    bag_t                 bag, bag_n;
    logic [tries_w-1:0]   tries, tries_n;
    logic                 valid_n;
    logic [idx_w-1:0]     item_n;
    logic [idx_w:0]       rem_n;

    logic [idx_w-1:0]     cand, lowest, pick;
    logic                 in_range, cand_ok, fallback;

    function automatic logic [width_p-1:0] lfsr_step(input logic [width_p-1:0] s);
        return (s >> 1) ^ (s[0] ? taps_p : '0);
    endfunction

    assign cand = lfsr[idx_w-1:0];

    always_comb begin
        lowest = '0;
        for (int i = num_items_p - 1; i >= 0; i--) begin
            if (bag[i]) lowest = idx_w'(i);
        end
    end

    // Candidate qualification; the fallback pick guarantees bounded draw latency.
    always_comb begin
        in_range = ({1'b0, cand} < n_c);
        cand_ok  = in_range && (!mode_i || ((bag & (bag_t'(1) << cand)) != '0));
        fallback = !cand_ok && (tries == last_try);
        pick     = cand;
        if (!cand_ok) begin
            if (mode_i)         pick = lowest;
            else if (!in_range) pick = cand - n_low;
        end
    end

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        bag_n   = bag;
        tries_n = tries;
        valid_n = valid_o;
        item_n  = item_o;
        rem_n   = remaining_o;
        case (state)
            FILL: begin
                bag_n   = '1;
                rem_n   = n_c;
                tries_n = '0;
                state_n = DRAW;
            end
            DRAW: begin
                lfsr_n = lfsr_step(lfsr);
                if (mode_i && bag == '0) begin
                    state_n = FILL;
                end else if (cand_ok || fallback) begin
                    item_n  = pick;
                    valid_n = 1'b1;
                    tries_n = '0;
                    state_n = OUT;
                    if (mode_i) begin
                        bag_n = bag & ~(bag_t'(1) << pick);
                        rem_n = remaining_o - one_rem;
                    end
                end else begin
                    tries_n = tries + one_try;
                end
            end
            OUT: begin
                if (ready_i) begin
                    valid_n = 1'b0;
                    state_n = (bag == '0) ? FILL : DRAW;
                end
            end
            default: state_n = FILL;
        endcase
        // Reseed wins over every other event; a coincident handshake still completes.
        if (seed_v_i) begin
            lfsr_n  = (seed_i == '0) ? seed_p : seed_i;
            bag_n   = '0;
            valid_n = 1'b0;
            tries_n = '0;
            state_n = FILL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= FILL;
            lfsr        <= seed_p;
            bag         <= '0;
            tries       <= '0;
            valid_o     <= 1'b0;
            item_o      <= '0;
            remaining_o <= '0;
        end else begin
            state       <= state_n;
            lfsr        <= lfsr_n;
            bag         <= bag_n;
            tries       <= tries_n;
            valid_o     <= valid_n;
            item_o      <= item_n;
            remaining_o <= rem_n;
        end
    end

endmodule
